// File: rtl/unreg_pkg.sv
// Shared types and constants for the next-state capture stage and its change FIFO.
package unreg_pkg;

    localparam int          WIDTH_DEF   = 16;
    localparam logic [15:0] RST_VAL_DEF = 16'h0000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_e;

    // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/unreg_chg_fifo.sv
// Synchronous FIFO queuing state-change words; stores a parity bit per entry
// when UNREG_STATE_BUF_PARITY_EN is defined.
module unreg_chg_fifo
    import unreg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
`ifdef UNREG_STATE_BUF_PARITY_EN
    input  logic             push_par,
    output logic             head_par,
`endif
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_word
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Equal addresses with differing wrap bits means the writer lapped the reader.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    assign head_word = mem[rd_ptr[AW-1:0]];

`ifdef UNREG_STATE_BUF_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (do_push) mem_par[wr_ptr[AW-1:0]] <= push_par;
    end

    assign head_par = mem_par[rd_ptr[AW-1:0]];
`endif

endmodule

// File: rtl/unreg_state_buf.sv
// State register behind the next-state network, with change FIFO, saturating
// change counter and RUN/FLUSH drain control. Optional: UNREG_STATE_BUF_PARITY_EN.
module unreg_state_buf
    import unreg_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter int               DEPTH   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             flush,
    output logic [WIDTH-1:0] state_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CNT_W-1:0] chg_cnt,
`ifdef UNREG_STATE_BUF_PARITY_EN
    output logic             out_par,
    output logic             par_err,
`endif
    output logic             busy
);

    fsm_e             fsm_q;
    fsm_e             fsm_d;
    logic             acc;
    logic             chg;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) return cnt;
        return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Change is judged against the state being replaced, not the incoming one.
    assign acc       = in_valid & in_ready;
    assign chg       = acc & (in_word != state_q);
    assign in_ready  = (fsm_q == RUN) & ~full;
    assign pop       = ~empty & out_ready;
    assign out_valid = ~empty;
    assign out_word  = empty ? '0 : head_word;
    assign busy      = (fsm_q == FLUSH);

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            RUN:     if (flush) fsm_d = FLUSH;
            FLUSH:   if (empty) fsm_d = RUN;
            default: fsm_d = RUN;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= RST_VAL;
            chg_cnt <= '0;
            fsm_q   <= RUN;
        end else begin
            if (acc) state_q <= in_word;
            if (chg) chg_cnt <= sat_inc(chg_cnt);
            fsm_q <= fsm_d;
        end
    end

`ifdef UNREG_STATE_BUF_PARITY_EN
    logic head_par;

    assign out_par = empty ? 1'b0 : head_par;

    always_ff @(posedge pclk) begin
        if (prst) par_err <= 1'b0;
        else      par_err <= out_valid & ((^out_word) != out_par);
    end
`endif

    unreg_chg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (pclk),
        .rst       (prst),
        .push      (chg),
        .push_word (in_word),
`ifdef UNREG_STATE_BUF_PARITY_EN
        .push_par  (^in_word),
        .head_par  (head_par),
`endif
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_word (head_word)
    );

endmodule

// File: tb/tb_unreg_state_buf.sv
// Bench for unreg_state_buf: directed scenarios plus randomized traffic against a queue-based model.
module tb_unreg_state_buf;

    logic        pclk = 1'b0;
    logic        prst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [15:0] in_word;
    logic        flush;
    logic [15:0] state_q, state_q2;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [15:0] out_word, out_word2;
    logic [7:0]  chg_cnt;
    logic [1:0]  chg_cnt2;
    logic        busy, busy2;
`ifdef UNREG_STATE_BUF_PARITY_EN
    logic        out_par, out_par2, par_err, par_err2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: plain queue of change words, current state, counters, drain mode.
    logic [15:0] m_state;
    logic [15:0] m_q[$];
    int          m_cnt;
    int          m_cnt2;
    bit          m_flush;

    always #5 pclk = ~pclk;

    unreg_state_buf dut (
        .pclk(pclk), .prst(prst), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .flush(flush), .state_q(state_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .chg_cnt(chg_cnt),
`ifdef UNREG_STATE_BUF_PARITY_EN
        .out_par(out_par), .par_err(par_err),
`endif
        .busy(busy)
    );

    unreg_state_buf #(.CNT_W(2)) dut2 (
        .pclk(pclk), .prst(prst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_word(in_word), .flush(flush), .state_q(state_q2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_word(out_word2), .chg_cnt(chg_cnt2),
`ifdef UNREG_STATE_BUF_PARITY_EN
        .out_par(out_par2), .par_err(par_err2),
`endif
        .busy(busy2)
    );

    function automatic bit exp_ready();
        return !m_flush && (m_q.size() < 4);
    endfunction

    function automatic logic [15:0] exp_word();
        return (m_q.size() > 0) ? m_q[0] : 16'h0000;
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit          acc, pop, chg, was_empty, pr, fl;
        logic [15:0] w;
        was_empty = (m_q.size() == 0);
        acc = in_valid && exp_ready();
        pop = !was_empty && out_ready;
        chg = acc && (in_word != m_state);
        w   = in_word;
        pr  = prst;
        fl  = flush;
        @(posedge pclk);
        #1;
        if (pr) begin
            m_state = 16'h0000;
            m_q.delete();
            m_cnt   = 0;
            m_cnt2  = 0;
            m_flush = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (chg) begin
                m_q.push_back(w);
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3)  m_cnt2++;
            end
            if (acc) m_state = w;
            if (!m_flush && fl)         m_flush = 1;
            else if (m_flush && was_empty) m_flush = 0;
        end
    endtask

    task automatic do_reset();
        prst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        prst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++; if (state_q !== 16'h0000) begin n_err++; $display("FAIL reset_state got %h want 0000", state_q); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (chg_cnt !== 8'd0) begin n_err++; $display("FAIL reset_chg_cnt got %0d want 0", chg_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (out_word !== 16'h0000) begin n_err++; $display("FAIL reset_out_word got %h want 0000", out_word); end
    endtask

    task automatic test_dup_words();
        logic [15:0] ws [3] = '{16'h00FF, 16'h00FF, 16'hA5A5};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_word = ws[i];
            tick();
            n_cmp++; if (state_q !== ws[i]) begin n_err++; $display("FAIL dup_state[%0d] got %h want %h", i, state_q, ws[i]); end
        end
        in_valid = 1'b0;
        n_cmp++; if (chg_cnt !== 8'd2) begin n_err++; $display("FAIL dup_chg_cnt got %0d want 2", chg_cnt); end
        n_cmp++; if (out_word !== 16'h00FF) begin n_err++; $display("FAIL dup_head0 got %h want 00ff", out_word); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_word !== 16'hA5A5) begin n_err++; $display("FAIL dup_head1 got %h want a5a5", out_word); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dup_drained got %b want 0", out_valid); end
    endtask

    task automatic test_full_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_word = 16'(i);
            tick();
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        in_word = 16'd5;
        tick();
        n_cmp++; if (state_q !== 16'd4) begin n_err++; $display("FAIL full_held got %h want 0004", state_q); end
        n_cmp++; if (out_word !== 16'd1) begin n_err++; $display("FAIL full_head got %h want 0001", out_word); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (state_q !== 16'd5) begin n_err++; $display("FAIL full_accept5 got %h want 0005", state_q); end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_word !== 16'(k)) begin n_err++; $display("FAIL full_order got %b/%h want 1/%h", out_valid, out_word, 16'(k)); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom); if (w == m_state) w = w ^ 16'h1;
            in_valid = 1'b1; in_word = w;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom); if (w == m_state) w = w ^ 16'h1;
            in_word = w;
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_word !== exp_word() || m_q.size() != 2) begin n_err++; $display("FAIL b2b_head[%0d] got %b/%h want 1/%h depth %0d", i, out_valid, out_word, exp_word(), m_q.size()); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_word !== exp_word()) begin n_err++; $display("FAIL b2b_drain got %h want %h", out_word, exp_word()); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int busy_cycles;
        logic [15:0] w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom); if (w == m_state) w = w ^ 16'h1;
            in_valid = 1'b1; in_word = w;
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            busy_cycles++;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (busy_cycles != 4) begin n_err++; $display("FAIL flush_busy_cycles got %0d want 4", busy_cycles); end
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_done got %b/%b want 0/1", out_valid, in_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_empty_busy got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_empty_run got %b want 0", busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_word = ~m_state;
            tick();
            if (i == 1) begin
                n_cmp++; if (chg_cnt2 !== 2'd2) begin n_err++; $display("FAIL sat2_mid got %0d want 2", chg_cnt2); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (chg_cnt !== 8'hFF) begin n_err++; $display("FAIL sat8 got %0d want 255", chg_cnt); end
        n_cmp++; if (chg_cnt2 !== 2'd3) begin n_err++; $display("FAIL sat2 got %0d want 3", chg_cnt2); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        logic [15:0] w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom); if (w == m_state) w = w ^ 16'h1;
            in_valid = 1'b1; in_word = w;
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstflush_busy got %b want 1", busy); end
        prst = 1'b1;
        tick();
        prst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstflush_ctrl got %b%b%b want 001", busy, out_valid, in_ready); end
        n_cmp++; if (state_q !== 16'h0000 || chg_cnt !== 8'd0 || out_word !== 16'h0000) begin n_err++; $display("FAIL rstflush_data got %h/%0d/%h want 0000/0/0000", state_q, chg_cnt, out_word); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            prst      = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_word   = ($urandom_range(0, 3) == 0) ? m_state : 16'($urandom);
            out_ready = $urandom_range(0, 1);
            tick();
            n_cmp++;
            if (state_q !== m_state || in_ready !== exp_ready() || out_valid !== (m_q.size() > 0) ||
                out_word !== exp_word() || chg_cnt !== 8'(m_cnt) || busy !== m_flush || chg_cnt2 !== 2'(m_cnt2)) begin
                n_err++;
                $display("FAIL rand[%0d] got st=%h rdy=%b ov=%b ow=%h cnt=%0d cnt2=%0d busy=%b want st=%h rdy=%b ov=%b ow=%h cnt=%0d cnt2=%0d busy=%b",
                         i, state_q, in_ready, out_valid, out_word, chg_cnt, chg_cnt2, busy,
                         m_state, exp_ready(), (m_q.size() > 0), exp_word(), m_cnt, m_cnt2, m_flush);
            end
        end
        prst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

`ifdef UNREG_STATE_BUF_PARITY_EN
    task automatic test_parity();
        logic [15:0] w;
        do_reset();
        w = 16'h1235;
        in_valid = 1'b1; in_word = w;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_par !== ^w || par_err !== 1'b0) begin n_err++; $display("FAIL par_clean got %b/%b want %b/0", out_par, par_err, ^w); end
        force dut.out_word = w ^ 16'h0001;
        tick();
        n_cmp++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_err got %b want 1", par_err); end
        release dut.out_word;
        tick();
        n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_clear got %b want 0", par_err); end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_state = '0; m_cnt = 0; m_cnt2 = 0; m_flush = 0;
        prst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_dup_words();
        test_full_backpressure();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_reset_mid_flush();
        test_random();
`ifdef UNREG_STATE_BUF_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
